// File: rtl/uart8_receiver.sv
// uart8_receiver: oversampled UART receive stage for 5-8 bit characters.
// The line is synchronized, the start bit is validated at its sample point,
// and data/parity/stop are each sampled once at SAMPLE_PT of their bit period.
// valid/ready note: valid is a one-clk strobe with no back-pressure; out and
// the error flags are stable from that strobe until the next one.
module uart8_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_PT  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       STB,
  input  logic [1:0] WLS,
  output logic [7:0] out,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_int
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_PT);
  localparam logic [CW-1:0] LAST_CNT   = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          armed;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic          par_bit;
  logic          par_err_nx;
  logic          pen_l;
  logic          eps_l;
  logic          sp_l;
  logic [1:0]    wls_l;
  logic [2:0]    last_idx;
  logic [7:0]    word_mask;
  logic          par_expected;

  // The second stop bit is never checked, so STB has no effect on reception.
  logic unused_stb;
  assign unused_stb = STB;

  assign busy         = (state != IDLE);
  assign last_idx     = 3'd4 + {1'b0, wls_l};
  assign word_mask    = 8'hFF >> (2'd3 - wls_l);
  // data is cleared at start, so the XOR only sees the received bits.
  assign par_expected = sp_l ? ~eps_l : (eps_l ? ^data : ~^data);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: advances only on baud_tick; valid is the only per-clk strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      data        <= '0;
      par_bit     <= 1'b0;
      par_err_nx  <= 1'b0;
      pen_l       <= 1'b0;
      eps_l       <= 1'b0;
      sp_l        <= 1'b0;
      wls_l       <= '0;
      out         <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_int   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (armed && !rx_s) begin
              state      <= START;
              tick_cnt   <= '0;
              bit_idx    <= '0;
              data       <= '0;
              par_bit    <= 1'b0;
              par_err_nx <= 1'b0;
              pen_l      <= PEN;
              eps_l      <= EPS;
              sp_l       <= SP;
              wls_l      <= WLS;
            end else if (rx_s) begin
              armed <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == SAMPLE_CNT && rx_s) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (tick_cnt == LAST_CNT) begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_idx  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == SAMPLE_CNT) data[bit_idx] <= rx_s;
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              if (bit_idx == last_idx) state <= pen_l ? PARITY : STOP;
              else bit_idx <= bit_idx + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == SAMPLE_CNT) begin
              par_bit    <= rx_s;
              par_err_nx <= (rx_s != par_expected);
            end
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == SAMPLE_CNT) begin
              out         <= data & word_mask;
              valid       <= 1'b1;
              framing_err <= ~rx_s;
              parity_err  <= pen_l & par_err_nx;
              break_int   <= (data == 8'h00) & ~rx_s & (pen_l ? ~par_bit : 1'b1);
              state       <= IDLE;
              armed       <= 1'b0;
              tick_cnt    <= '0;
              bit_idx     <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart8_receiver.sv
// Testbench for uart8_receiver: directed frames plus randomized frames, with a
// queue-based scoreboard fed at stimulus time and drained by a valid monitor.
module tb_uart8_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic       STB = 1'b0;
  logic [1:0] WLS = 2'b11;
  logic [7:0] out;
  logic       valid;
  logic       busy;
  logic       parity_err;
  logic       framing_err;
  logic       break_int;

  int n_tests = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_pushed = 0;
  logic [10:0] exp_q[$];

  uart8_receiver #(.OVERSAMPLE(16), .SAMPLE_PT(7)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .PEN(PEN), .EPS(EPS), .SP(SP), .STB(STB), .WLS(WLS),
    .out(out), .valid(valid), .busy(busy), .parity_err(parity_err),
    .framing_err(framing_err), .break_int(break_int)
  );

  // Clock and a baud tick every fourth clk.
  always #5 clk = ~clk;

  logic [1:0] div = 2'd0;
  always @(negedge clk) begin
    div = div + 2'd1;
    baud_tick = (div == 2'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  // Correct parity bit from the line-control rules.
  function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    int wlen;
    int ones;
    wlen = 5 + int'(wls);
    ones = $countones(d & 8'(((1 << wlen) - 1)));
    if (sp) return !eps;
    if (eps) return logic'(ones % 2);
    return !logic'(ones % 2);
  endfunction

  // Drive one frame and push the expected {out, parity_err, framing_err, break_int}.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] wls, input logic pen,
                            input logic eps, input logic sp, input logic stb,
                            input logic par, input logic stop_lvl, input logic scramble);
    int wlen;
    logic [7:0] m;
    logic pe, fe, bi;
    wlen = 5 + int'(wls);
    m  = d & 8'(((1 << wlen) - 1));
    pe = pen && (par != ref_parity(d, wls, eps, sp));
    fe = !stop_lvl;
    bi = (m == 8'h00) && !stop_lvl && (!pen || !par);
    exp_q.push_back({m, pe, fe, bi});
    n_pushed++;
    PEN = pen; EPS = eps; SP = sp; STB = stb; WLS = wls;
    rx = 1'b0;
    wait_ticks(8);
    check("busy_in_frame", busy, 1);
    wait_ticks(8);
    if (scramble) begin
      PEN = 1'($urandom); EPS = 1'($urandom); SP = 1'($urandom);
      STB = 1'($urandom); WLS = 2'($urandom);
    end
    for (int i = 0; i < wlen; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (pen) begin
      rx = par;
      wait_ticks(16);
    end
    rx = stop_lvl;
    wait_ticks(16);
    if (stb) begin
      rx = 1'b1;
      wait_ticks(16);
    end
    rx = 1'b1;
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n && valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got out=%0h pe=%0b fe=%0b bi=%0b expected no valid",
                 out, parity_err, framing_err, break_int);
      end else begin
        e = exp_q.pop_front();
        check("rx_char", {21'd0, out, parity_err, framing_err, break_int}, {21'd0, e});
      end
    end
  end

  initial begin
    int v0;
    logic [7:0] d;
    logic [1:0] wls;
    logic pen, eps, sp, stb, par, stop_lvl;

    // Reset state
    rst_n = 1'b0;
    wait_ticks(2);
    check("reset_out", out, 0);
    check("reset_flags", {valid, busy, parity_err, framing_err, break_int}, 0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 2'b11, 0, 0, 0, 0, 0, 1, 0);
    wait_ticks(8);
    check("busy_after_frame", busy, 0);

    // 7E1 0x35, good then bad parity
    send_frame(8'h35, 2'b10, 1, 1, 0, 0, 0, 1, 0);
    wait_ticks(4);
    send_frame(8'h35, 2'b10, 1, 1, 0, 0, 1, 1, 0);
    wait_ticks(4);

    // 5-bit stick parity 0x1F, parity bit 1 with EPS=0 then EPS=1
    send_frame(8'h1F, 2'b00, 1, 0, 1, 0, 1, 1, 0);
    wait_ticks(4);
    send_frame(8'h1F, 2'b00, 1, 1, 1, 0, 1, 1, 0);
    wait_ticks(8);

    // Glitch: 4 ticks low is a false start
    v0 = n_valid;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(24);
    check("glitch_busy", busy, 0);
    check("glitch_no_valid", n_valid, v0);
    send_frame(8'h3C, 2'b11, 0, 0, 0, 0, 0, 1, 0);
    wait_ticks(8);

    // Break: line low for three 8N1 frame times gives exactly one character
    PEN = 1'b0; EPS = 1'b0; SP = 1'b0; STB = 1'b0; WLS = 2'b11;
    v0 = n_valid;
    exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    n_pushed++;
    rx = 1'b0;
    wait_ticks(480);
    rx = 1'b1;
    wait_ticks(20);
    check("break_single_valid", n_valid, v0 + 1);
    send_frame(8'h55, 2'b11, 0, 0, 0, 0, 0, 1, 0);
    wait_ticks(8);

    // Reset during data bit 4 of a frame
    d = 8'h81;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(8);
    v0 = n_valid;
    rst_n = 1'b0;
    #1;
    check("midreset_out", out, 0);
    check("midreset_flags", {valid, busy, parity_err, framing_err, break_int}, 0);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(4);
    rst_n = 1'b1;
    wait_ticks(6);
    check("midreset_no_valid", n_valid, v0);
    send_frame(8'h81, 2'b11, 0, 0, 0, 0, 0, 1, 0);
    wait_ticks(8);
    check("midreset_single_valid", n_valid, v0 + 1);

    // Randomized frames, with control inputs scrambled mid-frame
    repeat (30) begin
      d   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      wls = 2'($urandom_range(0, 3));
      pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom); stb = 1'($urandom);
      par = ref_parity(d, wls, eps, sp);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop_lvl = ($urandom_range(0, 7) != 0);
      send_frame(d, wls, pen, eps, sp, stb, par, stop_lvl, 1);
      wait_ticks($urandom_range(3, 20));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("valid_count", n_valid, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
